mudi_issue_ctrl: RTL and testbench

//  E-stage issue controller for the multiply/divide unit: decodes the E-stage MD instruction and drives start/op/HI-LO write/read.

---
 rtl/mudi_issue_ctrl.sv | 100 ++++++++++
 tb/tb_mudi_issue_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mudi_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit with a private latency countdown.
// Optional busy cross-check against the MD unit enabled by defining MUDI_ISSUE_CHECK_EN.
module mudi_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_is_md,
    input  logic [3:0] e_op,
    input  logic       e_hold,
    input  logic       e_kill,
    input  logic       md_busy,
    output logic       start,
    output logic [2:0] mudi_op,
    output logic       hi_write,
    output logic       lo_write,
    output logic       hi_read,
    output logic       lo_read,
    output logic       stall_d,
    output logic       chk_err
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_t;

    logic [CNT_W-1:0] cnt;
    logic             issued;
    logic             is_arith;
    logic             is_mul;
    logic             is_mt;
    logic             fire;
    logic             busy_pred;

    always_comb begin
        is_arith  = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
        is_mul    = (e_op == OP_MULT) || (e_op == OP_MULTU);
        is_mt     = (e_op == OP_MTHI) || (e_op == OP_MTLO);
        // issued outranks the decode so a held instruction never fires twice
        fire      = ~reset & (is_arith | is_mt) & ~e_kill & ~issued & (cnt == '0);
        start     = fire & is_arith;
        mudi_op   = start ? 3'(e_op - 4'd1) : '0;
        hi_write  = fire & (e_op == OP_MTHI);
        lo_write  = fire & (e_op == OP_MTLO);
        hi_read   = ~reset & (e_op == OP_MFHI) & ~e_kill;
        lo_read   = ~reset & (e_op == OP_MFLO) & ~e_kill;
        busy_pred = ~reset & (start | (cnt != '0));
        stall_d   = d_is_md & busy_pred;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            issued <= 1'b0;
        end else begin
            if (start)
                cnt <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);

            if (fire && e_hold)
                issued <= 1'b1;
            else if (!e_hold || e_kill)
                issued <= 1'b0;
        end
    end

`ifdef MUDI_ISSUE_CHECK_EN
    logic chk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= 1'b0;
        end else if (busy_pred != md_busy) begin
            chk_q <= 1'b1;
`ifndef SYNTHESIS
            $display("mudi_issue_ctrl: busy prediction differs at %0t cnt=%0d", $time, cnt);
`endif
        end
    end

    assign chk_err = chk_q & ~reset;
`else
    logic unused_md_busy;
    assign unused_md_busy = md_busy;
    assign chk_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mudi_issue_ctrl.sv
// Scoreboard bench for mudi_issue_ctrl: a busy-until-cycle reference model predicts every
// cycle's outputs, a separate monitor compares them against the DUT on the falling edge.
module tb_mudi_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_is_md = 1'b0;
    logic [3:0] e_op = 4'd0;
    logic       e_hold = 1'b0;
    logic       e_kill = 1'b0;
    logic       md_busy = 1'b0;
    logic       start;
    logic [2:0] mudi_op;
    logic       hi_write, lo_write, hi_read, lo_read, stall_d, chk_err;

    mudi_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .d_is_md(d_is_md), .e_op(e_op), .e_hold(e_hold),
        .e_kill(e_kill), .md_busy(md_busy), .start(start), .mudi_op(mudi_op),
        .hi_write(hi_write), .lo_write(lo_write), .hi_read(hi_read), .lo_read(lo_read),
        .stall_d(stall_d), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic [2:0] mop;
        logic       hw, lw, hr, lr, st, ce;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: unit is busy for every cycle before busy_end; one fire per E instruction.
    int   cyc = 0;
    int   busy_end = 0;
    bit   fired = 1'b0;
    bit   chk = 1'b0;

    task automatic step(input bit rst, input bit dmd, input int op, input bit hold,
                        input bit kill, input bit flip);
        exp_t e;
        bit   arith, mt, idle, fire, busy;
        @(posedge clk);
        #1;
        arith = (op >= 1) && (op <= 4);
        mt    = (op == 5) || (op == 6);
        idle  = cyc >= busy_end;
        e     = '0;
        busy  = 1'b0;
        if (!rst) begin
            fire    = (arith || mt) && !kill && !fired && idle;
            e.start = fire && arith;
            e.mop   = e.start ? 3'(op - 1) : 3'd0;
            e.hw    = fire && (op == 5);
            e.lw    = fire && (op == 6);
            e.hr    = (op == 7) && !kill;
            e.lr    = (op == 8) && !kill;
            busy    = e.start || !idle;
            e.st    = dmd && busy;
`ifdef MUDI_ISSUE_CHECK_EN
            e.ce    = chk;
`endif
        end else begin
            fire = 1'b0;
        end

        reset   = rst;
        d_is_md = dmd;
        e_op    = 4'(op);
        e_hold  = hold;
        e_kill  = kill;
        md_busy = busy ^ flip;
        q.push_back(e);

        if (rst) begin
            fired    = 1'b0;
            busy_end = 0;
            chk      = 1'b0;
        end else begin
            if (e.start) busy_end = cyc + ((op <= 2) ? MUL_LAT : DIV_LAT) + 1;
            if (fire && hold) fired = 1'b1;
            else if (!hold || kill) fired = 1'b0;
            if (busy != md_busy) chk = 1'b1;
        end
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle-time %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("start",    int'(start),    int'(e.start));
                check("mudi_op",  int'(mudi_op),  int'(e.mop));
                check("hi_write", int'(hi_write), int'(e.hw));
                check("lo_write", int'(lo_write), int'(e.lw));
                check("hi_read",  int'(hi_read),  int'(e.hr));
                check("lo_read",  int'(lo_read),  int'(e.lr));
                check("stall_d",  int'(stall_d),  int'(e.st));
                check("chk_err",  int'(chk_err),  int'(e.ce));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // reset
        step(1, 0, 9, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        // mult then MD instr waiting in D
        step(0, 0, 1, 0, 0, 0);
        repeat (7) step(0, 1, 0, 0, 0, 0);
        // divu then mflo waiting in D, reaching E once released
        step(0, 0, 4, 0, 0, 0);
        repeat (11) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 8, 0, 0, 0);
        // mult held in E for three cycles
        repeat (3) step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 0, 0);
        // killed mtlo and killed div
        step(0, 0, 6, 0, 1, 0);
        step(0, 0, 3, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // held mthi fires once
        repeat (3) step(0, 0, 5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // reset mid-divide
        step(0, 0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // mult with md_busy disagreeing at T+2
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int op;
            op = ($urandom_range(1, 0) == 0) ? int'($urandom_range(8, 0))
                                              : int'($urandom_range(15, 0));
            step($urandom_range(199, 0) == 0, $urandom_range(1, 0) == 1, op,
                 $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0,
                 $urandom_range(299, 0) == 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
